cmd_decoder: RTL and testbench

Receive-side command decoder for the wave generator's serial link. It consumes characters from the UART receiver, echoes each one, and parses `*<cmd>[HHHH]<CR>` commands. It updates the sample-count, prescale and speed registers, issues a one-cycle go pulse, and requests OK/ERR/DATA responses from resp_gen over the send_resp_* handshake.

---
 rtl/cmd_resp_pkg.sv | 38 +++
 rtl/ascii_hex_dec.sv | 22 ++
 rtl/cmd_decoder.sv | 176 +++++++++++++++++
 tb/tb_cmd_decoder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_resp_pkg.sv
// Definitions shared by cmd_decoder and resp_gen: response codes, ASCII
// constants, command letters and the decoder FSM state type.
package cmd_resp_pkg;

   localparam logic [1:0] RESP_OK   = 2'b00;
   localparam logic [1:0] RESP_ERR  = 2'b01;
   localparam logic [1:0] RESP_DATA = 2'b11;

   localparam logic [7:0] ASCII_STAR = 8'h2a;
   localparam logic [7:0] ASCII_CR   = 8'h0d;

   // Upper case writes a register, lower case reads it back.
   localparam logic [7:0] CMD_WR_NSAMP    = 8'h4e;  // 'N'
   localparam logic [7:0] CMD_WR_PRESCALE = 8'h50;  // 'P'
   localparam logic [7:0] CMD_WR_SPEED    = 8'h53;  // 'S'
   localparam logic [7:0] CMD_RD_NSAMP    = 8'h6e;  // 'n'
   localparam logic [7:0] CMD_RD_PRESCALE = 8'h70;  // 'p'
   localparam logic [7:0] CMD_RD_SPEED    = 8'h73;  // 's'
   localparam logic [7:0] CMD_GO          = 8'h47;  // 'G'

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ARG,
      ST_TERM,
      ST_RESP
   } state_e;

   function automatic logic is_write_cmd(input logic [7:0] c);
      return (c == CMD_WR_NSAMP) || (c == CMD_WR_PRESCALE) || (c == CMD_WR_SPEED);
   endfunction

   function automatic logic is_noarg_cmd(input logic [7:0] c);
      return (c == CMD_RD_NSAMP) || (c == CMD_RD_PRESCALE) || (c == CMD_RD_SPEED) ||
             (c == CMD_GO);
   endfunction

endpackage

// File: rtl/ascii_hex_dec.sv
// Combinational ASCII to hex nibble decoder; accepts 0-9, a-f and A-F.
module ascii_hex_dec (
   input  logic [7:0] char_in,
   output logic       valid,
   output logic [3:0] nibble
);

   always_comb begin
      valid  = 1'b1;
      nibble = 4'h0;
      if (char_in >= 8'h30 && char_in <= 8'h39) begin
         nibble = char_in[3:0];
      end else if ((char_in >= 8'h41 && char_in <= 8'h46) ||
                   (char_in >= 8'h61 && char_in <= 8'h66)) begin
         // Letters a-f/A-F carry 1..6 in the low nibble.
         nibble = char_in[3:0] + 4'd9;
      end else begin
         valid = 1'b0;
      end
   end

endmodule

// File: rtl/cmd_decoder.sv
// Receive-side command decoder: echoes every received character, parses
// "*<cmd>[HHHH]<CR>", updates the control registers and requests responses.
module cmd_decoder
   import cmd_resp_pkg::*;
#(
   parameter logic [15:0] NSAMP_RST    = 16'd1,
   parameter logic [15:0] PRESCALE_RST = 16'd32,
   parameter logic [15:0] SPEED_RST    = 16'd1,
   parameter logic [15:0] NSAMP_MAX    = 16'd1024,
   parameter logic [15:0] PRESCALE_MIN = 16'd32
) (
   input  logic        clk_rx,
   input  logic        rst_clk_rx_n,
   input  logic        rx_data_rdy,
   input  logic [7:0]  rx_data,
   output logic        send_char_val,
   output logic [7:0]  send_char,
   output logic        send_resp_val,
   output logic [1:0]  send_resp_type,
   output logic [15:0] send_resp_data,
   input  logic        send_resp_done,
   output logic [15:0] nsamp_reg,
   output logic [15:0] prescale_reg,
   output logic [15:0] speed_reg,
   output logic        new_go
);

   state_e      state_q, state_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [15:0] arg_q, arg_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  resp_type_q, resp_type_d;
   logic [15:0] resp_data_q, resp_data_d;
   logic [15:0] nsamp_q, nsamp_d;
   logic [15:0] prescale_q, prescale_d;
   logic [15:0] speed_q, speed_d;
   logic        go_q, go_d;
   logic        hex_valid;
   logic [3:0]  hex_nibble;
   logic        syntax_err;

   ascii_hex_dec u_hex (
      .char_in (rx_data),
      .valid   (hex_valid),
      .nibble  (hex_nibble)
   );

   assign send_char_val  = rx_data_rdy;
   assign send_char      = rx_data;
   assign send_resp_val  = (state_q == ST_RESP);
   assign send_resp_type = resp_type_q;
   assign send_resp_data = resp_data_q;
   assign nsamp_reg      = nsamp_q;
   assign prescale_reg   = prescale_q;
   assign speed_reg      = speed_q;
   assign new_go         = go_q;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      arg_d       = arg_q;
      cnt_d       = cnt_q;
      resp_type_d = resp_type_q;
      resp_data_d = resp_data_q;
      nsamp_d     = nsamp_q;
      prescale_d  = prescale_q;
      speed_d     = speed_q;
      go_d        = 1'b0;
      syntax_err  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_data_rdy && rx_data == ASCII_STAR) begin
               state_d = ST_CMD;
               arg_d   = '0;
               cnt_d   = '0;
            end
         end
         ST_CMD: begin
            if (rx_data_rdy) begin
               cmd_d = rx_data;
               if (is_write_cmd(rx_data))       state_d = ST_ARG;
               else if (is_noarg_cmd(rx_data))  state_d = ST_TERM;
               else                             syntax_err = 1'b1;
            end
         end
         ST_ARG: begin
            if (rx_data_rdy) begin
               if (hex_valid) begin
                  arg_d = {arg_q[11:0], hex_nibble};
                  cnt_d = cnt_q + 2'd1;
                  if (cnt_q == 2'd3) state_d = ST_TERM;
               end else begin
                  syntax_err = 1'b1;
               end
            end
         end
         ST_TERM: begin
            if (rx_data_rdy) begin
               if (rx_data == ASCII_CR) begin
                  // Execute: result and register update land together one cycle after CR.
                  state_d     = ST_RESP;
                  resp_type_d = RESP_OK;
                  resp_data_d = '0;
                  case (cmd_q)
                     CMD_WR_NSAMP: begin
                        if (arg_q != '0 && arg_q <= NSAMP_MAX) nsamp_d = arg_q;
                        else resp_type_d = RESP_ERR;
                     end
                     CMD_WR_PRESCALE: begin
                        if (arg_q >= PRESCALE_MIN) prescale_d = arg_q;
                        else resp_type_d = RESP_ERR;
                     end
                     CMD_WR_SPEED: speed_d = arg_q;
                     CMD_RD_NSAMP: begin
                        resp_type_d = RESP_DATA;
                        resp_data_d = nsamp_q;
                     end
                     CMD_RD_PRESCALE: begin
                        resp_type_d = RESP_DATA;
                        resp_data_d = prescale_q;
                     end
                     CMD_RD_SPEED: begin
                        resp_type_d = RESP_DATA;
                        resp_data_d = speed_q;
                     end
                     CMD_GO:  go_d = 1'b1;
                     default: resp_type_d = RESP_ERR;
                  endcase
               end else begin
                  syntax_err = 1'b1;
               end
            end
         end
         ST_RESP: begin
            if (send_resp_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (syntax_err) begin
         state_d     = ST_RESP;
         resp_type_d = RESP_ERR;
         resp_data_d = '0;
      end
   end

   // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
      if (!rst_clk_rx_n) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         arg_q       <= '0;
         cnt_q       <= '0;
         resp_type_q <= RESP_OK;
         resp_data_q <= '0;
         nsamp_q     <= NSAMP_RST;
         prescale_q  <= PRESCALE_RST;
         speed_q     <= SPEED_RST;
         go_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         arg_q       <= arg_d;
         cnt_q       <= cnt_d;
         resp_type_q <= resp_type_d;
         resp_data_q <= resp_data_d;
         nsamp_q     <= nsamp_d;
         prescale_q  <= prescale_d;
         speed_q     <= speed_d;
         go_q        <= go_d;
      end
   end

endmodule

// File: tb/tb_cmd_decoder.sv
// Scoreboard bench for cmd_decoder: a string-level command model predicts each
// response; separate monitors check echoes, responses, go pulses and registers.
module tb_cmd_decoder;

   logic        clk_rx = 1'b0;
   logic        rst_clk_rx_n = 1'b0;
   logic        rx_data_rdy = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        send_char_val;
   logic [7:0]  send_char;
   logic        send_resp_val;
   logic [1:0]  send_resp_type;
   logic [15:0] send_resp_data;
   logic        send_resp_done = 1'b0;
   logic [15:0] nsamp_reg, prescale_reg, speed_reg;
   logic        new_go;

   cmd_decoder dut (
      .clk_rx         (clk_rx),
      .rst_clk_rx_n   (rst_clk_rx_n),
      .rx_data_rdy    (rx_data_rdy),
      .rx_data        (rx_data),
      .send_char_val  (send_char_val),
      .send_char      (send_char),
      .send_resp_val  (send_resp_val),
      .send_resp_type (send_resp_type),
      .send_resp_data (send_resp_data),
      .send_resp_done (send_resp_done),
      .nsamp_reg      (nsamp_reg),
      .prescale_reg   (prescale_reg),
      .speed_reg      (speed_reg),
      .new_go         (new_go)
   );

   always #5 clk_rx = ~clk_rx;

   typedef struct {
      logic [1:0]  rtype;
      logic [15:0] data;
      logic        go;
      logic [15:0] nsamp;
      logic [15:0] prescale;
      logic [15:0] speed;
      int          due;
   } exp_t;

   exp_t       resp_q[$];
   logic [7:0] echo_q[$];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;

   logic [15:0] m_nsamp = 16'd1;
   logic [15:0] m_prescale = 16'd32;
   logic [15:0] m_speed = 16'd1;

   always @(posedge clk_rx) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic bit is_hex(input logic [7:0] c);
      return (c >= "0" && c <= "9") || (c >= "a" && c <= "f") || (c >= "A" && c <= "F");
   endfunction

   function automatic int hex_val(input logic [7:0] c);
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "a" && c <= "f") return int'(c) - 87;
      return int'(c) - 55;
   endfunction

   // Walks one command string; reports how many characters the decoder consumes
   // before it answers, the expected answer, and applies any register write.
   function automatic void model_cmd(input string s, output int used, output exp_t e);
      logic [7:0]  c, ch;
      logic [15:0] arg;
      int          nhex;
      bit          ok;
      c = s[1];
      used = 2;
      ok = 1'b0;
      arg = 16'd0;
      e.rtype = 2'b01;
      e.data = 16'd0;
      e.go = 1'b0;
      e.due = 0;
      if (c inside {"N", "P", "S", "n", "p", "s", "G"}) begin
         nhex = (c inside {"N", "P", "S"}) ? 4 : 0;
         ok = 1'b1;
         for (int i = 0; i < nhex && ok; i++) begin
            ch = s[2 + i];
            used = 3 + i;
            if (is_hex(ch)) arg = 16'(32'(arg) * 16 + hex_val(ch));
            else ok = 1'b0;
         end
         if (ok) begin
            ch = s[2 + nhex];
            used = 3 + nhex;
            ok = (ch == 8'h0d);
         end
      end
      if (ok) begin
         e.rtype = 2'b00;
         case (c)
            "N": if (arg >= 16'd1 && arg <= 16'd1024) m_nsamp = arg; else e.rtype = 2'b01;
            "P": if (arg >= 16'd32) m_prescale = arg; else e.rtype = 2'b01;
            "S": m_speed = arg;
            "n": begin e.rtype = 2'b11; e.data = m_nsamp; end
            "p": begin e.rtype = 2'b11; e.data = m_prescale; end
            "s": begin e.rtype = 2'b11; e.data = m_speed; end
            default: e.go = 1'b1;
         endcase
      end
      e.nsamp = m_nsamp;
      e.prescale = m_prescale;
      e.speed = m_speed;
   endfunction

   // Monitor: every echo, every rising send_resp_val and every go pulse is checked here.
   exp_t me;
   logic prev_val = 1'b0;
   always @(negedge clk_rx) begin
      if (!rst_clk_rx_n) begin
         prev_val <= 1'b0;
      end else begin
         if (send_char_val || echo_q.size() != 0) begin
            if (echo_q.size() == 0) begin
               check("echo_spurious", 32'(send_char_val), 32'd0);
            end else begin
               check("echo_val", 32'(send_char_val), 32'd1);
               check("echo_char", 32'(send_char), 32'(echo_q.pop_front()));
            end
         end
         if (send_resp_val && !prev_val) begin
            if (resp_q.size() == 0) begin
               check("resp_spurious", 32'(send_resp_val), 32'd0);
            end else begin
               me = resp_q.pop_front();
               check("resp_latency", 32'(cyc), 32'(me.due));
               check("resp_type", 32'(send_resp_type), 32'(me.rtype));
               check("resp_data", 32'(send_resp_data), 32'(me.data));
               check("nsamp_reg", 32'(nsamp_reg), 32'(me.nsamp));
               check("prescale_reg", 32'(prescale_reg), 32'(me.prescale));
               check("speed_reg", 32'(speed_reg), 32'(me.speed));
               check("new_go", 32'(new_go), 32'(me.go));
            end
         end else if (new_go) begin
            check("go_stray", 32'(new_go), 32'd0);
         end
         prev_val <= send_resp_val;
      end
   end

   // Called at posedge+1; leaves the character on the bus for exactly one cycle.
   task automatic drive_char(input logic [7:0] c, output int dc);
      rx_data_rdy = 1'b1;
      rx_data = c;
      echo_q.push_back(c);
      dc = cyc;
      @(posedge clk_rx); #1;
      rx_data_rdy = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic send_cmd(input string s, input string during, input int delay, input bit do_done);
      exp_t e;
      int   used, dc;
      bit   got;
      model_cmd(s, used, e);
      for (int i = 0; i < used; i++) begin
         drive_char(s[i], dc);
         if (i < used - 1) repeat ($urandom_range(0, 2)) begin @(posedge clk_rx); #1; end
      end
      e.due = dc + 1;
      resp_q.push_back(e);
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
         @(negedge clk_rx);
         got = send_resp_val;
      end
      if (!got) begin
         check("resp_timeout", 32'(send_resp_val), 32'd1);
         resp_q.delete();
         @(posedge clk_rx); #1;
         return;
      end
      @(posedge clk_rx); #1;
      if (!do_done) return;
      for (int i = 0; i < during.len(); i++) drive_char(during[i], dc);
      repeat (delay) begin @(posedge clk_rx); #1; end
      send_resp_done = 1'b1;
      @(negedge clk_rx);
      check("resp_held", 32'(send_resp_val), 32'd1);
      check("resp_type_stable", 32'(send_resp_type), 32'(e.rtype));
      check("resp_data_stable", 32'(send_resp_data), 32'(e.data));
      @(posedge clk_rx); #1;
      send_resp_done = 1'b0;
      @(negedge clk_rx);
      check("resp_fall", 32'(send_resp_val), 32'd0);
      @(posedge clk_rx); #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_resp_val"}, 32'(send_resp_val), 32'd0);
      check({tag, "_resp_type"}, 32'(send_resp_type), 32'd0);
      check({tag, "_resp_data"}, 32'(send_resp_data), 32'd0);
      check({tag, "_new_go"}, 32'(new_go), 32'd0);
      check({tag, "_nsamp"}, 32'(nsamp_reg), 32'd1);
      check({tag, "_prescale"}, 32'(prescale_reg), 32'd32);
      check({tag, "_speed"}, 32'(speed_reg), 32'd1);
   endtask

   // Asserts reset between clock edges and checks that outputs clear without a clock.
   task automatic async_reset(input string tag);
      #2 rst_clk_rx_n = 1'b0;
      #1 check_reset_state(tag);
      m_nsamp = 16'd1;
      m_prescale = 16'd32;
      m_speed = 16'd1;
      resp_q.delete();
      @(negedge clk_rx);
      rst_clk_rx_n = 1'b1;
      @(posedge clk_rx); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      string      s, letters, bad;
      logic [7:0] l;
      logic [15:0] v;
      int         dc, pos;
      letters = "NPSnpsGQ*x";
      bad = "G\r*z";

      #12 check_reset_state("por");
      @(negedge clk_rx);
      rst_clk_rx_n = 1'b1;
      @(posedge clk_rx); #1;

      send_cmd("*n\r", "", 2, 1'b1);
      send_cmd("*p\r", "", 0, 1'b1);
      send_cmd("*N0100\r", "", 3, 1'b1);
      send_cmd("*n\r", "", 1, 1'b1);
      send_cmd("*N0000\r", "", 1, 1'b1);
      send_cmd("*N0401\r", "", 1, 1'b1);
      send_cmd("*N0400\r", "", 0, 1'b1);
      send_cmd("*P001F\r", "", 1, 1'b1);
      send_cmd("*P0020\r", "", 1, 1'b1);
      send_cmd("*SBeEf\r", "", 1, 1'b1);
      send_cmd("*s\r", "", 1, 1'b1);
      send_cmd("*Q", "", 1, 1'b1);
      send_cmd("*N12G", "", 1, 1'b1);
      send_cmd("*N12\r", "", 1, 1'b1);
      send_cmd("*n5", "", 1, 1'b1);
      send_cmd("**", "", 1, 1'b1);
      send_cmd("*S12*", "", 1, 1'b1);
      send_cmd("*G\r", "", 2, 1'b1);

      // Characters arriving during a long response are echoed but never parsed.
      send_cmd("*p\r", "*s\r", 47, 1'b1);
      repeat (5) begin @(posedge clk_rx); #1; end

      for (int n = 0; n < 60; n++) begin
         l = letters[$urandom_range(0, 9)];
         case ($urandom_range(0, 5))
            0: v = 16'd0;
            1: v = 16'd1;
            2: v = 16'd1024;
            3: v = 16'd1025;
            4: v = 16'($urandom_range(0, 63));
            default: v = 16'($urandom);
         endcase
         if (l inside {"N", "P", "S"}) s = $sformatf("*%c%04h\r", l, v);
         else s = $sformatf("*%c\r", l);
         if ($urandom_range(0, 7) == 0) begin
            pos = $urandom_range(1, s.len() - 1);
            s[pos] = bad[$urandom_range(0, 3)];
         end
         if ($urandom_range(0, 4) == 0) drive_char(($urandom_range(0, 1) == 1) ? 8'h0d : 8'h41, dc);
         send_cmd(s, "", $urandom_range(0, 4), 1'b1);
      end

      drive_char("*", dc);
      drive_char("S", dc);
      drive_char("1", dc);
      drive_char("2", dc);
      async_reset("rst_mid_arg");
      send_cmd("*N0100\r", "", 0, 1'b0);
      async_reset("rst_mid_resp");
      send_cmd("*s\r", "", 1, 1'b1);
      send_cmd("*n\r", "", 1, 1'b1);

      repeat (5) begin @(posedge clk_rx); #1; end
      check("sb_resp_drained", 32'(resp_q.size()), 32'd0);
      check("sb_echo_drained", 32'(echo_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
